seq_pattern_tx: RTL and testbench
=================================

Name: seq_pattern_tx

Overview:
Serial pattern transmitter. It is the source side of the serial sequence-detector interface: it drives a one-bit-per-clock stream (e.g. 1101 frames) into the Mealy detectors.
Each accepted start transmits a latched PAT_W-bit pattern MSB-first, a programmable number of times, with a programmable number of idle zero bits between frames.
It reports progress through busy, done and a completed-frame counter. It is used as stimulus/traffic source for the detector blocks and as a standalone serializer.

Parameters:
PAT_W, 4, pattern width in bits (min 2)
CNT_W, 4, width of repeat count and tx_count
GAP_W, 3, width of inter-frame gap count

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
pattern  input  PAT_W  frame bits, sent MSB first
repeat  input  CNT_W  number of frames to send; 0 = request ignored
gap  input  GAP_W  idle cycles between frames; 0 = back-to-back
out  output  1  serial data bit
out_valid  output  1  high while out carries a pattern bit
busy  output  1  high from the cycle after acceptance through the last bit or gap cycle
done  output  1  one-cycle pulse after the last bit of the last frame
tx_count  output  CNT_W  frames completed in the current/last request

Behaviour:
- Clocking: one clock. Reset is asynchronous and active-high.
- All outputs are registered or decoded from registers only; no combinational path from inputs to outputs.
- Reset (async, any state, including mid-frame): state=IDLE, out=0, out_valid=0, busy=0, done=0, tx_count=0, bit index=0, shadow registers=0. Effect is immediate on assertion, not at the next edge. The first start is accepted at the first rising edge after deassertion.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - start=1 and repeat!=0 at edge E0: latch pattern/repeat/gap into shadow registers; clear tx_count; bit index=0; go SHIFT.
  - pattern MSB is on out with out_valid=1 in the cycle following E0 (latency 1).
  - start=1 with repeat=0: no state change, no done, tx_count unchanged.
- SHIFT:
  - out = shadow_pattern[PAT_W-1-idx]; out_valid=1; busy=1.
  - idx increments each cycle.
  - At the edge ending bit idx=PAT_W-1: tx_count+=1, idx=0. Then:
    - new tx_count == shadow_repeat -> DONE.
    - else gap==0 -> stay SHIFT (next frame MSB next cycle, no bubble).
    - else -> GAP.
- GAP: out=0, out_valid=0, busy=1 for exactly shadow_gap cycles, then SHIFT.
- DONE: exactly one cycle with done=1, busy=0, out=0, out_valid=0; then IDLE. start in this cycle is ignored.
- Invariants:
  - out=0 whenever out_valid=0.
  - start, pattern, repeat and gap are ignored while busy or in DONE.
  - Input changes mid-request have no effect; shadow registers are used throughout.
- Request duration: busy high for repeat*PAT_W + (repeat-1)*gap cycles; done follows immediately.
- tx_count: holds its final value in IDLE until the next accepted start clears it. It never wraps, since repeat <= 2^CNT_W-1.
- Max-value boundaries must not overflow internal counters:
  - repeat = 2^CNT_W-1
  - gap = 2^GAP_W-1

Test Plan:
1. Reset: assert rst mid-cycle while idle -> all outputs 0 immediately; hold 12 ns, release; outputs stay 0 with no start.
2. pattern=1101, repeat=1, gap=0, start one cycle:
   - out_valid=1 for 4 cycles with out=1,1,0,1.
   - done=1 in the 5th cycle, busy low that cycle.
   - tx_count=1; a 1101 non-overlapping detector on the stream fires once.
3. pattern=1101, repeat=3, gap=0:
   - 12 consecutive valid cycles, stream 110111011101.
   - tx_count steps 1,2,3; a single done pulse; the non-overlapping detector fires 3 times.
4. pattern=1101, repeat=2, gap=2:
   - out stream 1101, then 2 cycles out=0/out_valid=0, then 1101.
   - busy high 10 cycles, then done.
   - Repeat with gap=7, repeat=15 -> busy = 15*4+14*7 = 158 cycles, tx_count=15.
5. Ignored requests:
   - start with repeat=0 -> no busy, no done.
   - start pulsed and pattern changed to 0000 during SHIFT, and start in the DONE cycle -> stream unchanged, single done, no restart.
6. Reset mid-SHIFT (after the 2nd bit of frame 2 of 3):
   - outputs clear asynchronously, tx_count=0, no done.
   - A new start with pattern=1011, repeat=1 afterwards yields 1,0,1,1 then done.

Source files
------------

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched PAT_W-bit pattern MSB-first a
// programmable number of times, with a programmable idle gap between frames.
// The repeat count arrives on port repeat_cnt because "repeat" is a reserved word.
module seq_pattern_tx #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] tx_count
);

    localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [PAT_W-1:0]   pat_sh_q, pat_sh_d;
    logic [CNT_W-1:0]   rep_sh_q, rep_sh_d;
    logic [GAP_W-1:0]   gap_sh_q, gap_sh_d;
    logic [CNT_W-1:0]   tx_count_q, tx_count_d;
    logic               out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   tx_next_s;

    // Bit of p at MSB-first position i
    function automatic logic bit_at(input logic [PAT_W-1:0] p, input logic [IDX_W-1:0] i);
        logic [PAT_W-1:0] shifted;
        shifted = p << i;
        return shifted[PAT_W-1];
    endfunction

    // Next-state, shadow-register and counter update
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        gap_cnt_d  = gap_cnt_q;
        pat_sh_d   = pat_sh_q;
        rep_sh_d   = rep_sh_q;
        gap_sh_d   = gap_sh_q;
        tx_count_d = tx_count_q;
        tx_next_s  = tx_count_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (start && (repeat_cnt != '0)) begin
                    pat_sh_d   = pattern;
                    rep_sh_d   = repeat_cnt;
                    gap_sh_d   = gap;
                    tx_count_d = '0;
                    idx_d      = '0;
                    state_d    = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (idx_q == IDX_LAST) begin
                    idx_d      = '0;
                    tx_count_d = tx_next_s;
                    if (tx_next_s == rep_sh_q) begin
                        state_d = S_DONE;
                    end else if (gap_sh_q == '0) begin
                        state_d = S_SHIFT;
                    end else begin
                        gap_cnt_d = gap_sh_q;
                        state_d   = S_GAP;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_GAP: begin
                // gap_cnt is loaded with the gap length and counts down to 1
                if (gap_cnt_q <= GAP_W'(1)) begin
                    gap_cnt_d = '0;
                    state_d   = S_SHIFT;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next register state
    always_comb begin
        out_valid_d = (state_d == S_SHIFT);
        busy_d      = (state_d == S_SHIFT) || (state_d == S_GAP);
        done_d      = (state_d == S_DONE);
        if (out_valid_d) begin
            out_d = bit_at(pat_sh_d, idx_d);
        end else begin
            out_d = 1'b0;
        end
    end

    // State, shadow and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            gap_cnt_q   <= '0;
            pat_sh_q    <= '0;
            rep_sh_q    <= '0;
            gap_sh_q    <= '0;
            tx_count_q  <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gap_cnt_q   <= gap_cnt_d;
            pat_sh_q    <= pat_sh_d;
            rep_sh_q    <= rep_sh_d;
            gap_sh_q    <= gap_sh_d;
            tx_count_q  <= tx_count_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign tx_count  = tx_count_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: stimulus pushes expected stream bits and
// completion records; a negedge monitor pops and compares them.
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] pattern = 4'b0000;
    logic [3:0] repeat_cnt = 4'd0;
    logic [2:0] gap = 3'd0;
    logic       out;
    logic       out_valid;
    logic       busy;
    logic       done;
    logic [3:0] tx_count;

    typedef struct {
        int cnt;
        int blen;
    } done_t;

    bit    exp_bits[$];
    done_t exp_done[$];
    int    checks = 0;
    int    errors = 0;
    int    busy_len = 0;
    int    dones_seen = 0;

    seq_pattern_tx #(.PAT_W(4), .CNT_W(4), .GAP_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern),
        .repeat_cnt(repeat_cnt), .gap(gap), .out(out), .out_valid(out_valid),
        .busy(busy), .done(done), .tx_count(tx_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out"}, int'(out), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_tx_count"}, int'(tx_count), 0);
    endtask

    task automatic push_frames(input logic [3:0] p, input int r);
        for (int f = 0; f < r; f++) begin
            for (int b = 3; b >= 0; b--) begin
                exp_bits.push_back(p[b]);
            end
        end
    endtask

    // Request a transfer; optionally record expectations and leave start high
    task automatic issue(input logic [3:0] p, input int r, input int g,
                         input bit do_push, input bit hold_start);
        done_t d;
        if (do_push && r != 0) begin
            push_frames(p, r);
            d.cnt  = r;
            d.blen = r * 4 + (r - 1) * g;
            exp_done.push_back(d);
        end
        @(posedge clk);
        #2;
        start      = 1'b1;
        pattern    = p;
        repeat_cnt = 4'(r);
        gap        = 3'(g);
        @(posedge clk);
        #2;
        if (!hold_start) begin
            start = 1'b0;
        end
    endtask

    task automatic wait_done(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 400 cycles", name);
        end
    endtask

    // Monitor: compare stream bits and completion records as the DUT presents them
    always @(negedge clk) begin
        if (rst) begin
            busy_len = 0;
        end else begin
            if (out_valid) begin
                if (exp_bits.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_bit: got out_valid=1 out=%0b expected no output", out);
                end else begin
                    chk("stream_bit", int'(out), int'(exp_bits.pop_front()));
                end
            end else begin
                chk("idle_out_zero", int'(out), 0);
            end
            if (busy) begin
                busy_len++;
            end
            if (done) begin
                dones_seen++;
                chk("done_busy_low", int'(busy), 0);
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_done: got done=1 tx_count=%0d expected no done", tx_count);
                end else begin
                    done_t d;
                    d = exp_done.pop_front();
                    chk("done_tx_count", int'(tx_count), d.cnt);
                    chk("busy_cycles", busy_len, d.blen);
                end
                busy_len = 0;
            end
        end
    end

    initial begin
        int d0;
        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("por");
        #2;
        rst = 1'b0;

        // Single frame 1101
        issue(4'b1101, 1, 0, 1'b1, 1'b0);
        wait_done("single");
        repeat (2) @(negedge clk);
        chk("single_hold_tx_count", int'(tx_count), 1);

        // Asynchronous reset while idle clears the held count at once
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_all_zero("idle_rst");
        #11;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("post_rst");

        // Back-to-back frames
        issue(4'b1101, 3, 0, 1'b1, 1'b0);
        wait_done("rep3");
        repeat (3) @(negedge clk);
        chk("rep3_hold_tx_count", int'(tx_count), 3);

        // Gapped frames, then maximum repeat and gap
        issue(4'b1101, 2, 2, 1'b1, 1'b0);
        wait_done("gap2");
        issue(4'b1101, 15, 7, 1'b1, 1'b0);
        wait_done("max");
        repeat (2) @(negedge clk);
        chk("max_tx_count", int'(tx_count), 15);

        // repeat=0 request is ignored
        d0 = dones_seen;
        issue(4'b1111, 0, 0, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        chk("rep0_busy", int'(busy), 0);
        chk("rep0_tx_count", int'(tx_count), 15);
        chk("rep0_no_done", dones_seen, d0);

        // start held through SHIFT and DONE, inputs changed mid-request
        issue(4'b1101, 2, 1, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        pattern    = 4'b0000;
        repeat_cnt = 4'd5;
        gap        = 3'd0;
        wait_done("held_start");
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("held_no_restart_busy", int'(busy), 0);
        chk("held_tx_count", int'(tx_count), 2);

        // Reset after the 2nd bit of frame 2 of 3
        push_frames(4'b1101, 1);
        exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b1);
        d0 = dones_seen;
        issue(4'b1101, 3, 0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        chk("mid_rst_bits_consumed", exp_bits.size(), 0);
        #11;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_rst_no_done", dones_seen, d0);
        issue(4'b1011, 1, 0, 1'b1, 1'b0);
        wait_done("after_rst");

        repeat (3) @(negedge clk);
        chk("bits_left", exp_bits.size(), 0);
        chk("dones_left", exp_done.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
